// File: rtl/cgra_mem_port_arbiter_if.sv
// Bus bundle between the CGRA memory units, the port arbiter and the shared RAM macro.
// The arbiter takes the slave side. The CGRA and RAM environment takes the master side.
interface cgra_mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            lock;
  logic [NUM_PORTS-1:0]            w_rq;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]            gnt;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic [ADDR_WIDTH-1:0]           ram_addr_to_ram;
  logic [DATA_WIDTH-1:0]           ram_data_in_to_ram;
  logic                            ram_w_rq_to_ram;
  logic                            ram_en_to_ram;
  logic [DATA_WIDTH-1:0]           ram_data_out_from_ram;

  modport slave (
    input  req, lock, w_rq, addr, wdata, ram_data_out_from_ram,
    output gnt, rvalid, rdata, ram_addr_to_ram, ram_data_in_to_ram,
           ram_w_rq_to_ram, ram_en_to_ram
  );

  modport master (
    output req, lock, w_rq, addr, wdata, ram_data_out_from_ram,
    input  gnt, rvalid, rdata, ram_addr_to_ram, ram_data_in_to_ram,
           ram_w_rq_to_ram, ram_en_to_ram
  );
endinterface

// File: rtl/cgra_mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM among NUM_PORTS CGRA memory units.
// It supports a bounded lock and returns tagged read data. CGRA_ARB_PERF_COUNTERS_EN adds grant and stall counters.
module cgra_mem_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                   CGRA_Clock,
  input  logic                   CGRA_Reset_n,
  cgra_mem_port_arbiter_if.slave bus
`ifdef CGRA_ARB_PERF_COUNTERS_EN
  ,
  input  logic                   perf_clear,
  output logic [NUM_PORTS*16-1:0] perf_grants,
  output logic [NUM_PORTS*16-1:0] perf_stalls
`endif
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);
  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  tag_vld_q, tag_vld_d;
  logic [PW-1:0]         tag_idx_q, tag_idx_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic                  gnt_any;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         cand;
  logic                  lock_hit;
  logic [NUM_PORTS-1:0]  gnt_vec;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lock owner wins while it still requests and has budget left. Otherwise the search starts at the pointer.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    lock_hit = owner_vld_q && bus.req[owner_q] && (cnt_q < LOCK_MAX);
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        cand = PW'((int'(ptr_q) + k) % NUM_PORTS);
        if (bus.req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt_vec                = gnt_any ? (ONE_HOT0 << gnt_idx) : '0;
  assign bus.gnt                = gnt_vec;
  assign bus.ram_en_to_ram      = gnt_any;
  assign bus.ram_w_rq_to_ram    = gnt_any & bus.w_rq[gnt_idx];
  assign bus.ram_addr_to_ram    = ram_addr_d;
  assign bus.ram_data_in_to_ram = ram_wdata_d;
  assign bus.rvalid             = tag_vld_q ? (ONE_HOT0 << tag_idx_q) : '0;
  assign bus.rdata              = tag_vld_q ? bus.ram_data_out_from_ram : '0;

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = '0;
    owner_vld_d = 1'b0;
    cnt_d       = '0;
    tag_vld_d   = 1'b0;
    tag_idx_d   = gnt_idx;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (gnt_any) begin
      ptr_d       = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      tag_vld_d   = ~bus.w_rq[gnt_idx];
      ram_addr_d  = addr_arr[gnt_idx];
      ram_wdata_d = wdata_arr[gnt_idx];
      if (bus.lock[gnt_idx]) begin
        owner_vld_d = 1'b1;
        owner_d     = gnt_idx;
        // An exhausted lock that wins again through round-robin starts a fresh budget.
        cnt_d = (owner_vld_q && owner_q == gnt_idx && cnt_q < LOCK_MAX) ? cnt_q + 4'd1 : 4'd1;
      end
    end
  end

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
    if (!CGRA_Reset_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
      tag_vld_q   <= 1'b0;
      tag_idx_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef CGRA_ARB_PERF_COUNTERS_EN
  logic [15:0] grants_q [NUM_PORTS];
  logic [15:0] stalls_q [NUM_PORTS];

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
    if (!CGRA_Reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grants_q[i] <= '0;
        stalls_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (perf_clear) begin
          grants_q[i] <= '0;
          stalls_q[i] <= '0;
        end else begin
          if (gnt_vec[i] && grants_q[i] != 16'hFFFF)
            grants_q[i] <= grants_q[i] + 16'd1;
          if (bus.req[i] && !gnt_vec[i] && stalls_q[i] != 16'hFFFF)
            stalls_q[i] <= stalls_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_perf
    assign perf_grants[i*16 +: 16] = grants_q[i];
    assign perf_stalls[i*16 +: 16] = stalls_q[i];
  end
`endif

endmodule

// File: tb/tb_cgra_mem_port_arbiter.sv
// This bench drives directed vectors and runs a behavioural model of the arbiter and a RAM.
// A negedge compare process checks every output each cycle. Literal checks pin the model.
module tb_cgra_mem_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cgra_mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cgra_mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .CGRA_Clock  (clk),
    .CGRA_Reset_n(rst_n),
    .bus         (bus)
  );

  logic [3:0]  t_req, t_lock, t_wrq;
  logic [31:0] p_addr  [NP];
  logic [31:0] p_wdata [NP];
  assign bus.req   = t_req;
  assign bus.lock  = t_lock;
  assign bus.w_rq  = t_wrq;
  assign bus.addr  = {p_addr[3], p_addr[2], p_addr[1], p_addr[0]};
  assign bus.wdata = {p_wdata[3], p_wdata[2], p_wdata[1], p_wdata[0]};

  // RAM macro: synchronous single port with registered read data
  logic [31:0] ram_mem [1024];
  logic [31:0] ram_dout = '0;
  assign bus.ram_data_out_from_ram = ram_dout;
  always @(posedge clk) begin
    if (bus.ram_en_to_ram) begin
      if (bus.ram_w_rq_to_ram) ram_mem[bus.ram_addr_to_ram[11:2]] <= bus.ram_data_in_to_ram;
      else                     ram_dout <= ram_mem[bus.ram_addr_to_ram[11:2]];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [3:0] v, input int i);
    logic [1:0] ix;
    ix = i[1:0];
    return v[ix];
  endfunction

  // Behavioural model state
  logic [31:0] model_mem [1024];
  int          m_ptr = 0, m_owner = -1, m_cnt = 0;
  bit          m_pend = 0;
  int          m_pend_port = 0;
  logic [31:0] m_pend_data = '0;
  logic [31:0] m_last_addr = '0, m_last_wd = '0;
  int          glog[$];

  always @(negedge clk) begin
    int eg, dg;
    logic [3:0]  e_gnt, e_rv;
    logic [31:0] e_addr, e_wd;
    bit          e_w;
    dg = -1;
    for (int i = 0; i < NP; i++) if (bit_of(bus.gnt, i)) dg = (dg == -1) ? i : -2;
    if (!rst_n) begin
      chk("rst_gnt", 64'(bus.gnt), 64'd0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
      chk("rst_rdata", 64'(bus.rdata), 64'd0);
      chk("rst_ram_en", 64'(bus.ram_en_to_ram), 64'd0);
      chk("rst_ram_wrq", 64'(bus.ram_w_rq_to_ram), 64'd0);
      chk("rst_ram_addr", 64'(bus.ram_addr_to_ram), 64'd0);
      chk("rst_ram_din", 64'(bus.ram_data_in_to_ram), 64'd0);
      m_ptr = 0; m_owner = -1; m_cnt = 0; m_pend = 0;
      m_last_addr = '0; m_last_wd = '0;
    end else begin
      glog.push_back(dg);
      eg = -1;
      if (m_owner >= 0 && bit_of(t_req, m_owner) && m_cnt < ML) eg = m_owner;
      else
        for (int k = 0; k < NP; k++)
          if (eg < 0 && bit_of(t_req, (m_ptr + k) % NP)) eg = (m_ptr + k) % NP;
      e_gnt  = (eg >= 0) ? 4'(1 << eg) : 4'd0;
      e_w    = (eg >= 0) ? bit_of(t_wrq, eg) : 1'b0;
      e_addr = (eg >= 0) ? p_addr[eg] : m_last_addr;
      e_wd   = (eg >= 0) ? p_wdata[eg] : m_last_wd;
      e_rv   = m_pend ? 4'(1 << m_pend_port) : 4'd0;
      chk("gnt", 64'(bus.gnt), 64'(e_gnt));
      chk("ram_en", 64'(bus.ram_en_to_ram), 64'(eg >= 0));
      chk("ram_w_rq", 64'(bus.ram_w_rq_to_ram), 64'(e_w));
      chk("ram_addr", 64'(bus.ram_addr_to_ram), 64'(e_addr));
      chk("ram_din", 64'(bus.ram_data_in_to_ram), 64'(e_wd));
      chk("rvalid", 64'(bus.rvalid), 64'(e_rv));
      chk("rdata", 64'(bus.rdata), m_pend ? 64'(m_pend_data) : 64'd0);
      // Advance the model across the coming rising edge
      m_pend = 0;
      if (eg >= 0) begin
        m_last_addr = e_addr;
        m_last_wd   = e_wd;
        if (e_w) model_mem[e_addr[11:2]] = e_wd;
        else begin
          m_pend = 1; m_pend_port = eg; m_pend_data = model_mem[e_addr[11:2]];
        end
        m_ptr = (eg + 1) % NP;
        if (bit_of(t_lock, eg)) begin
          m_cnt   = (m_owner == eg && m_cnt < ML) ? m_cnt + 1 : 1;
          m_owner = eg;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
  end

  task automatic clear_ports();
    t_req = '0; t_lock = '0; t_wrq = '0;
    for (int i = 0; i < NP; i++) begin p_addr[i] = '0; p_wdata[i] = '0; end
  endtask

  task automatic set_port(input int p, input bit l, input bit w, input logic [31:0] a, input logic [31:0] d);
    t_req[p[1:0]] = 1'b1; t_lock[p[1:0]] = l; t_wrq[p[1:0]] = w;
    p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    clear_ports();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_seq(input string nm, input int exp[8]);
    chk({nm, "_len"}, 64'(glog.size()), 64'd8);
    if (glog.size() == 8)
      for (int i = 0; i < 8; i++) chk(nm, 64'(glog[i]), 64'(exp[i]));
  endtask

  int fair_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int lock_exp[8] = '{1, 1, 1, 1, 3, 1, 1, 1};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]   = 32'h5A00_0000 + 32'(i * 3);
      model_mem[i] = 32'h5A00_0000 + 32'(i * 3);
    end
    ram_mem[10'h280]   = 32'h0001_0000;
    model_mem[10'h280] = 32'h0001_0000;
    clear_ports();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (10) begin
      @(posedge clk); #3;
      chk("idle_gnt", 64'(bus.gnt), 64'd0);
      chk("idle_en", 64'(bus.ram_en_to_ram), 64'd0);
      chk("idle_rvalid", 64'(bus.rvalid), 64'd0);
    end

    // Fairness: four continuous readers
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, 1'b0, 32'h0100 + 32'(i * 4), '0);
    glog.delete();
    repeat (8) @(posedge clk);
    #1 clear_ports();
    check_seq("fair_seq", fair_exp);

    // Single read from port 2
    @(posedge clk); #1;
    set_port(2, 1'b0, 1'b0, 32'h0A00, '0);
    #2 chk("single_gnt", 64'(bus.gnt), 64'h4);
    @(posedge clk); #1 clear_ports();
    #2 chk("single_rvalid", 64'(bus.rvalid), 64'h4);
    chk("single_rdata", 64'(bus.rdata), 64'h0001_0000);

    // Lock bound
    apply_reset();
    set_port(1, 1'b1, 1'b0, 32'h0010, '0);
    set_port(3, 1'b0, 1'b0, 32'h0020, '0);
    glog.delete();
    repeat (8) @(posedge clk);
    #1 clear_ports();
    check_seq("lock_seq", lock_exp);

    // Write then read from another port
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b1, 32'h0C04, 32'hDEAD_BEEF);
    #2 chk("wr_gnt", 64'(bus.gnt), 64'h1);
    chk("wr_strobe", 64'(bus.ram_w_rq_to_ram), 64'd1);
    @(posedge clk); #1 clear_ports();
    set_port(3, 1'b0, 1'b0, 32'h0C04, '0);
    #2 chk("wr_no_rvalid", 64'(bus.rvalid), 64'd0);
    chk("raw_gnt", 64'(bus.gnt), 64'h8);
    @(posedge clk); #1 clear_ports();
    #2 chk("raw_rvalid", 64'(bus.rvalid), 64'h8);
    chk("raw_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);

    // Lock owner drops req
    @(posedge clk); #1;
    set_port(2, 1'b1, 1'b0, 32'h0040, '0);
    repeat (2) @(posedge clk);
    #1 clear_ports();
    set_port(0, 1'b0, 1'b0, 32'h0044, '0);
    #2 chk("drop_gnt", 64'(bus.gnt), 64'h1);

    // Unaligned address passes through
    @(posedge clk); #1 clear_ports();
    set_port(1, 1'b0, 1'b0, 32'h0A03, '0);
    #2 chk("unal_addr", 64'(bus.ram_addr_to_ram), 64'h0A03);
    @(posedge clk); #1 clear_ports();
    #2 chk("unal_rdata", 64'(bus.rdata), 64'h0001_0000);

    // Reset during a read
    @(posedge clk); #1;
    set_port(1, 1'b0, 1'b0, 32'h0A00, '0);
    #2 chk("mid_gnt", 64'(bus.gnt), 64'h2);
    #3 rst_n = 1'b0;
    clear_ports();
    @(posedge clk); #1 chk("mid_rvalid", 64'(bus.rvalid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    set_port(1, 1'b0, 1'b0, 32'h0008, '0);
    set_port(3, 1'b0, 1'b0, 32'h000C, '0);
    #2 chk("post_rst_gnt", 64'(bus.gnt), 64'h2);
    chk("post_rst_rvalid", 64'(bus.rvalid), 64'd0);
    repeat (3) @(posedge clk);
    #1 clear_ports();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cgra_mem_port_arbiter.md
Name: cgra_mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM among NUM_PORTS CGRA memory units (mem_N_mem_unit_* interfaces).
- Replaces the multi-ported RAM model on physical builds.
- Round-robin arbitration with one access per cycle, optional bounded lock for back-to-back accesses, and routing of registered read data back to the issuing port.
- Sits between the cgra top level and the RAM macro, in the CGRA clock domain.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, byte address width, passed through unchanged.
- DATA_WIDTH, 32, data word width.
- MAX_LOCK, 4, maximum consecutive grants to one port while its lock is held (1..15).

Ports:
- CGRA_Clock  in  1  CGRA clock; all state on its rising edge.
- CGRA_Reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  per-port access request; held until granted.
- lock  in  NUM_PORTS  per-port request to keep the grant next cycle.
- w_rq  in  NUM_PORTS  per-port write(1)/read(0) select.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port byte address (port i at slice i).
- wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- gnt  out  NUM_PORTS  one-hot grant; the access is issued this cycle.
- rvalid  out  NUM_PORTS  one-hot read-data valid.
- rdata  out  DATA_WIDTH  read data, shared bus, qualified by rvalid.
- ram_addr_to_ram  out  ADDR_WIDTH  RAM byte address (RAM applies >>2).
- ram_data_in_to_ram  out  DATA_WIDTH  RAM write data.
- ram_w_rq_to_ram  out  1  RAM write strobe.
- ram_en_to_ram  out  1  RAM access enable.
- ram_data_out_from_ram  in  DATA_WIDTH  RAM read data, registered, 1-cycle latency.

Behaviour:
Reset (CGRA_Reset_n low, asynchronous):
- gnt=0, rvalid=0, rdata=0, ram_en=0, ram_w_rq=0, ram_addr=0, ram_data_in=0.
- Priority pointer=0, lock owner cleared, lock count=0, read tag cleared.
- Reset asserted mid-access drops any pending rvalid; no late rvalid after release.

Arbitration (combinational within the cycle):
- If a lock owner L is set, req[L] is high, and lock count < MAX_LOCK: grant L.
- Otherwise grant the first asserted req searching from the pointer upward, wrapping modulo NUM_PORTS.
- No req asserted: gnt=0, ram_en=0, RAM outputs hold their previous values.
- Granted port's addr, wdata and w_rq drive the RAM outputs in the same cycle. ram_w_rq = w_rq & grant.

State update on each clock edge with a grant to port g:
- Pointer <= (g+1) mod NUM_PORTS. Locked grants still advance the pointer, so fairness resumes when the lock ends.
- If lock[g] is high: owner <= g; count <= count+1 if g was already the owner, else 1.
- If lock[g] is low: owner cleared, count <= 0.
- When count reaches MAX_LOCK: the lock is forced off for one arbitration round, so other requesters get a turn; the owner is then cleared.
- Owner drops req while locked: lock released immediately, and normal round-robin applies that cycle.

Reads:
- A read granted at cycle T registers tag {valid, g}.
- At T+1: rvalid[g]=1 and rdata=ram_data_out_from_ram.
- Back-to-back reads from different ports pipeline at one per cycle.

Writes:
- Committed by the RAM at the grant edge; no rvalid is produced.

Read-after-write to the same address from a different port on the next cycle returns the new data, since the RAM write completes first.

Non-word-aligned addresses are passed through unchanged; the RAM ignores addr[1:0].

Optional Feature:
- Macro: CGRA_ARB_PERF_COUNTERS_EN.
- When defined, adds:
  - Output perf_grants (NUM_PORTS*16): per-port grant counter.
  - Output perf_stalls (NUM_PORTS*16): per-port counter, incremented on cycles where req is high and gnt is low.
  - Input perf_clear (1): synchronous clear of both counters.
- Counters saturate at 16'hFFFF and are reset asynchronously to 0. perf_clear takes priority over increment in the same cycle.
- When undefined: none of these ports or registers exist, and arbitration behaviour is identical.

Test Plan:
- Reset then idle: req=0 for 10 cycles -> gnt=0, rvalid=0, ram_en=0 throughout; all outputs 0 after reset.
- Single read: port 2 reads addr 32'h0A00, RAM word 0x280 holds 32'h00010000 -> gnt=4'b0100 at T; rvalid=4'b0100 and rdata=32'h00010000 at T+1.
- Fairness: all four ports request continuously, no lock, for 8 cycles -> grants follow 0,1,2,3,0,1,2,3; each port granted exactly 2 times.
- Lock bound with MAX_LOCK=4: port 1 holds req and lock, port 3 holds req -> port 1 granted 4 consecutive cycles, then port 3, then port 1 again.
- Write then read: port 0 writes 32'hDEADBEEF to 32'h0C04 at T; port 3 reads 32'h0C04 at T+1 -> rvalid[3] at T+2 with rdata=32'hDEADBEEF.
- Reset mid-read: read granted at T, CGRA_Reset_n pulled low before edge T+1 -> rvalid stays 0 and the pointer returns to 0; the first grant after reset goes to the lowest requesting port.
